cavlc_top: RTL and testbench
============================

# cavlc_top

CAVLC front-end statistics and level/run extractor for the H.264 encoder residual path. It accepts one quantized 4x4 block of signed 8-bit coefficients and reorders it into zig-zag scan order. It reports the CAVLC syntax counts (TotalCoeff, TrailingOnes with signs, TotalZeros), then streams the non-zero levels with their run_before values in reverse scan order, ready for the downstream bitstream table/packer stage.

## Interface
Parameters: none; widths are fixed by the package.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- valid  in  1  single-cycle block strobe; coefficients are sampled on the same edge
- scaleRC_i (R,C = 0..3, 16 ports scale00_i … scale33_i)  in  8 each  signed two's-complement coefficient at row R, column C
- busy  out  1  block in progress; valid is ignored while high
- stats_valid  out  1  one-cycle pulse: the four count outputs are new
- total_coeff  out  5  non-zero coefficients, 0..16
- trailing_ones_cnt  out  2  trailing ±1 count, 0..3
- trailing_ones_flag  out  3  bit i = 1 when the i-th trailing one is negative (bit0 = highest frequency)
- total_zero_cnt  out  4  zeros before the last non-zero coefficient in scan order
- level_valid  out  1  level_o and run_before_o are valid this cycle
- level_o  out  8  signed non-zero coefficient
- run_before_o  out  4  zeros immediately below this coefficient in scan order
- level_last  out  1  qualifies the final level of the block

## Operation
- Zig-zag index k to (row,col): 0:00 1:01 2:10 3:20 4:11 5:02 6:03 7:12 8:21 9:30 10:31 11:22 12:13 13:23 14:32 15:33.
- total_coeff = count of z[k] ≠ 0.
- Trailing ones: scan k = 15 down to 0 and skip zeros. Count coefficients with |z| = 1, stop at the first |z| > 1, cap at 3. Unused flag bits are 0.
- total_zero_cnt = zeros at indices below the highest non-zero index. It is 0 when total_coeff = 0.
- Emission: non-zeros are emitted from the highest index to the lowest, one per cycle. run_before_o = count of consecutive zeros directly below the current index. For the lowest non-zero this is the number of zeros below it.
- FSM states:
  - IDLE: valid → CALC.
  - CALC: goes to EMIT if total_coeff > 0, else IDLE.
  - EMIT: stays until the lowest non-zero has been emitted, then IDLE.
- busy = (state ≠ IDLE).

## Timing
- Edge N with valid=1 and state IDLE: the block is captured and busy rises.
- Edge N+1: count outputs are registered and stats_valid = 1 for one cycle. Count outputs hold until the next block.
- Edges N+2 … N+1+total_coeff: one level per cycle with level_valid=1. level_last is high on the last one. busy falls on the edge after the last level.
- All-zero block: returns to IDLE at N+1 and emits no levels.
- valid while busy is dropped, not queued. A new valid is accepted on the edge busy is low.
- Reset: all outputs 0 and state IDLE. Reset has priority over valid, and a reset mid-block abandons the block.

## Structure
- Package cavlc_pkg:
  - zig-zag index constant array
  - state enum {IDLE, CALC, EMIT}
  - width localparams (COEF_W=8, TC_W=5)
- Sub-module cavlc_stats is purely combinational: from the 16 scan-ordered coefficients it produces total_coeff, trailing ones count/flags and total zeros.
- The top holds the capture register, the FSM, and an emission pointer. A priority encoder selects the next non-zero below the pointer.

## Test plan
- Block rows {-12,7,0,1},{7,1,-3,0},{0,-5,-3,0},{0,-2,2,1}:
  - counts: total_coeff=11, trailing_ones_cnt=1, trailing_ones_flag=000, total_zero_cnt=5
  - level/run stream, 11 levels over cycles N+2..N+12, level_last on -12: (1,0)(2,2)(-3,0)(-2,1)(-5,0)(-3,0)(1,1)(1,1)(7,0)(7,0)(-12,0)
- Block {-10,-1,-1,-1},{-3,-1,-1,0},{0,0,-1,-1},{-1,0,-1,-1}: total_coeff=12, trailing_ones_cnt=3, flag=111, total_zero_cnt=4.
- All-zero block: all counts 0, stats_valid pulses, no level_valid, busy high for exactly one cycle.
- Only s33=-1:
  - counts: total_coeff=1, T1=1, flag=001, total_zero_cnt=15
  - one level (-1, run 15) with level_last
- valid reasserted while busy with a different block: that block is ignored and outputs match the first block only.
- rst asserted during EMIT: next cycle all outputs 0 and busy 0. A fresh block then processes correctly.

Source files
------------

// File: rtl/cavlc_pkg.sv
// CAVLC front-end shared types and constants.
// Zig-zag table maps scan index to raster position (row*4+col).
package cavlc_pkg;
  localparam int COEF_W = 8;
  localparam int TC_W = 5;
  localparam int ZZ_N = 16;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    EMIT
  } state_e;

  localparam logic [3:0] ZZ_POS [ZZ_N] = '{
    4'd0, 4'd1, 4'd4, 4'd8,
    4'd5, 4'd2, 4'd3, 4'd6,
    4'd9, 4'd12, 4'd13, 4'd10,
    4'd7, 4'd11, 4'd14, 4'd15
  };
endpackage

// File: rtl/cavlc_stats.sv
// CAVLC block statistics over scan-ordered coefficients.
// Purely combinational: TotalCoeff, TrailingOnes, TotalZeros.
module cavlc_stats
  import cavlc_pkg::*;
(
  input  coef_t           z_i [ZZ_N],
  output logic [TC_W-1:0] total_coeff_o,
  output logic [1:0]      t1_cnt_o,
  output logic [2:0]      t1_flag_o,
  output logic [3:0]      total_zeros_o
);
  logic [TC_W-1:0] hi_plus1;
  logic            stop;

  always_comb begin
    total_coeff_o = '0;
    hi_plus1 = '0;
    t1_cnt_o = '0;
    t1_flag_o = '0;
    stop = 1'b0;
    for (int k = 0; k < ZZ_N; k++) begin
      if (z_i[k] != '0) begin
        total_coeff_o = total_coeff_o + 1'b1;
        hi_plus1 = TC_W'(k + 1);
      end
    end
    // a fourth +-1 or any larger magnitude ends the trailing-ones run
    for (int k = ZZ_N - 1; k >= 0; k--) begin
      if (z_i[k] != '0 && !stop) begin
        if ((z_i[k] == COEF_W'(1) || z_i[k] == '1)
            && t1_cnt_o != 2'd3) begin
          t1_flag_o[t1_cnt_o] = z_i[k][COEF_W-1];
          t1_cnt_o = t1_cnt_o + 1'b1;
        end else begin
          stop = 1'b1;
        end
      end
    end
    total_zeros_o = 4'(hi_plus1 - total_coeff_o);
  end
endmodule

// File: rtl/cavlc_top.sv
// CAVLC front end: capture, zig-zag, stats, and reverse-scan
// level/run_before stream for the bitstream packer.
module cavlc_top
  import cavlc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid,
  input  logic signed [COEF_W-1:0] scale00_i,
  input  logic signed [COEF_W-1:0] scale01_i,
  input  logic signed [COEF_W-1:0] scale02_i,
  input  logic signed [COEF_W-1:0] scale03_i,
  input  logic signed [COEF_W-1:0] scale10_i,
  input  logic signed [COEF_W-1:0] scale11_i,
  input  logic signed [COEF_W-1:0] scale12_i,
  input  logic signed [COEF_W-1:0] scale13_i,
  input  logic signed [COEF_W-1:0] scale20_i,
  input  logic signed [COEF_W-1:0] scale21_i,
  input  logic signed [COEF_W-1:0] scale22_i,
  input  logic signed [COEF_W-1:0] scale23_i,
  input  logic signed [COEF_W-1:0] scale30_i,
  input  logic signed [COEF_W-1:0] scale31_i,
  input  logic signed [COEF_W-1:0] scale32_i,
  input  logic signed [COEF_W-1:0] scale33_i,
  output logic                     busy,
  output logic                     stats_valid,
  output logic [TC_W-1:0]          total_coeff,
  output logic [1:0]               trailing_ones_cnt,
  output logic [2:0]               trailing_ones_flag,
  output logic [3:0]               total_zero_cnt,
  output logic                     level_valid,
  output logic signed [COEF_W-1:0] level_o,
  output logic [3:0]               run_before_o,
  output logic                     level_last
);
  state_e          state_q, state_d;
  coef_t           raster [ZZ_N];
  coef_t           zz_in [ZZ_N];
  coef_t           coef_q [ZZ_N];
  coef_t           coef_d [ZZ_N];
  logic [4:0]      ptr_q, ptr_d;
  logic            sv_q, sv_d;
  logic [TC_W-1:0] tc_q, tc_d;
  logic [1:0]      t1c_q, t1c_d;
  logic [2:0]      t1f_q, t1f_d;
  logic [3:0]      tz_q, tz_d;
  logic            lv_q, lv_d;
  coef_t           lvl_q, lvl_d;
  logic [3:0]      run_q, run_d;
  logic            last_q, last_d;
  logic [TC_W-1:0] s_tc;
  logic [1:0]      s_t1c;
  logic [2:0]      s_t1f;
  logic [3:0]      s_tz;
  logic [3:0]      cur_idx, below_idx, run_w;
  logic            below_found;

  always_comb begin
    raster = '{scale00_i, scale01_i, scale02_i, scale03_i,
               scale10_i, scale11_i, scale12_i, scale13_i,
               scale20_i, scale21_i, scale22_i, scale23_i,
               scale30_i, scale31_i, scale32_i, scale33_i};
    for (int k = 0; k < ZZ_N; k++) zz_in[k] = raster[ZZ_POS[k]];
  end

  cavlc_stats u_stats (
    .z_i           (coef_q),
    .total_coeff_o (s_tc),
    .t1_cnt_o      (s_t1c),
    .t1_flag_o     (s_t1f),
    .total_zeros_o (s_tz)
  );

  // highest non-zero below the pointer, and the next one below that
  always_comb begin
    cur_idx = '0;
    below_idx = '0;
    below_found = 1'b0;
    for (int k = 0; k < ZZ_N; k++)
      if (coef_q[k] != '0 && 5'(k) < ptr_q) cur_idx = 4'(k);
    for (int k = 0; k < ZZ_N; k++)
      if (coef_q[k] != '0 && 4'(k) < cur_idx) begin
        below_idx = 4'(k);
        below_found = 1'b1;
      end
    run_w = below_found ? cur_idx - below_idx - 4'd1 : cur_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      coef_q <= '{default: '0};
      ptr_q <= '0;
      sv_q <= 1'b0;
      tc_q <= '0;
      t1c_q <= '0;
      t1f_q <= '0;
      tz_q <= '0;
      lv_q <= 1'b0;
      lvl_q <= '0;
      run_q <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      coef_q <= coef_d;
      ptr_q <= ptr_d;
      sv_q <= sv_d;
      tc_q <= tc_d;
      t1c_q <= t1c_d;
      t1f_q <= t1f_d;
      tz_q <= tz_d;
      lv_q <= lv_d;
      lvl_q <= lvl_d;
      run_q <= run_d;
      last_q <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (valid) state_d = CALC;
      CALC: state_d = (s_tc != '0) ? EMIT : IDLE;
      EMIT: if (last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    coef_d = coef_q;
    ptr_d = ptr_q;
    sv_d = 1'b0;
    tc_d = tc_q;
    t1c_d = t1c_q;
    t1f_d = t1f_q;
    tz_d = tz_q;
    lv_d = 1'b0;
    lvl_d = '0;
    run_d = '0;
    last_d = 1'b0;
    case (state_q)
      IDLE: if (valid) coef_d = zz_in;
      CALC: begin
        sv_d = 1'b1;
        tc_d = s_tc;
        t1c_d = s_t1c;
        t1f_d = s_t1f;
        tz_d = s_tz;
        ptr_d = 5'd16;
      end
      EMIT: if (!last_q) begin
        lv_d = 1'b1;
        lvl_d = coef_q[cur_idx];
        run_d = run_w;
        last_d = !below_found;
        ptr_d = {1'b0, cur_idx};
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign stats_valid = sv_q;
  assign total_coeff = tc_q;
  assign trailing_ones_cnt = t1c_q;
  assign trailing_ones_flag = t1f_q;
  assign total_zero_cnt = tz_q;
  assign level_valid = lv_q;
  assign level_o = lvl_q;
  assign run_before_o = run_q;
  assign level_last = last_q;
endmodule

// File: tb/tb_cavlc_top.sv
// Self-checking bench for cavlc_top: directed test-plan blocks
// plus random blocks against a scan-list reference model.
module tb_cavlc_top;
  logic clk = 1'b0;
  logic rst, valid;
  logic signed [7:0] drv [4][4];
  logic signed [7:0] blk [4][4];
  logic busy, stats_valid, level_valid, level_last;
  logic [4:0] total_coeff;
  logic [1:0] trailing_ones_cnt;
  logic [2:0] trailing_ones_flag;
  logic [3:0] total_zero_cnt, run_before_o;
  logic signed [7:0] level_o;

  int checks = 0;
  int errors = 0;
  int exp_tc, exp_t1, exp_flag, exp_tz;
  int exp_lv[$];
  int exp_rb[$];
  int zr[16] = '{0,0,1,2,1,0,0,1,2,3,3,2,1,2,3,3};
  int zc[16] = '{0,1,0,0,1,2,3,2,1,0,1,2,3,3,2,3};

  always #5 clk = ~clk;

  cavlc_top dut (
    .clk(clk), .rst(rst), .valid(valid),
    .scale00_i(drv[0][0]), .scale01_i(drv[0][1]),
    .scale02_i(drv[0][2]), .scale03_i(drv[0][3]),
    .scale10_i(drv[1][0]), .scale11_i(drv[1][1]),
    .scale12_i(drv[1][2]), .scale13_i(drv[1][3]),
    .scale20_i(drv[2][0]), .scale21_i(drv[2][1]),
    .scale22_i(drv[2][2]), .scale23_i(drv[2][3]),
    .scale30_i(drv[3][0]), .scale31_i(drv[3][1]),
    .scale32_i(drv[3][2]), .scale33_i(drv[3][3]),
    .busy(busy), .stats_valid(stats_valid),
    .total_coeff(total_coeff),
    .trailing_ones_cnt(trailing_ones_cnt),
    .trailing_ones_flag(trailing_ones_flag),
    .total_zero_cnt(total_zero_cnt),
    .level_valid(level_valid), .level_o(level_o),
    .run_before_o(run_before_o), .level_last(level_last)
  );

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_row(input int r, input int a, input int b,
                         input int c, input int d);
    blk[r][0] = 8'(a);
    blk[r][1] = 8'(b);
    blk[r][2] = 8'(c);
    blk[r][3] = 8'(d);
  endtask

  task automatic clear_blk();
    for (int r = 0; r < 4; r++) set_row(r, 0, 0, 0, 0);
  endtask

  // Reference: list the non-zeros in scan order, derive everything from it.
  task automatic model();
    int idx[$];
    int val[$];
    int v, lo;
    for (int k = 0; k < 16; k++) begin
      v = blk[zr[k]][zc[k]];
      if (v != 0) begin
        idx.push_back(k);
        val.push_back(v);
      end
    end
    exp_tc = idx.size();
    exp_tz = (exp_tc > 0) ? idx[exp_tc-1] + 1 - exp_tc : 0;
    exp_t1 = 0;
    exp_flag = 0;
    for (int i = exp_tc - 1; i >= 0; i--) begin
      if (exp_t1 == 3 || !(val[i] == 1 || val[i] == -1)) break;
      if (val[i] < 0) exp_flag = exp_flag | (1 << exp_t1);
      exp_t1++;
    end
    exp_lv.delete();
    exp_rb.delete();
    for (int i = exp_tc - 1; i >= 0; i--) begin
      lo = (i > 0) ? idx[i-1] : -1;
      exp_lv.push_back(val[i]);
      exp_rb.push_back(idx[i] - lo - 1);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sv"}, stats_valid, 0);
    chk({tag, "_tc"}, total_coeff, 0);
    chk({tag, "_t1"}, trailing_ones_cnt, 0);
    chk({tag, "_flag"}, trailing_ones_flag, 0);
    chk({tag, "_tz"}, total_zero_cnt, 0);
    chk({tag, "_lv"}, level_valid, 0);
    chk({tag, "_lvl"}, $signed(level_o), 0);
    chk({tag, "_run"}, run_before_o, 0);
    chk({tag, "_last"}, level_last, 0);
  endtask

  // Starts at #1 after an edge with the DUT idle.
  task automatic run_block(input int inject, input int rst_at);
    model();
    drv = blk;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    chk("cap_busy", busy, 1);
    chk("cap_sv", stats_valid, 0);
    @(posedge clk); #1;
    chk("sv", stats_valid, 1);
    chk("tc", total_coeff, exp_tc);
    chk("t1", trailing_ones_cnt, exp_t1);
    chk("flag", trailing_ones_flag, exp_flag);
    chk("tz", total_zero_cnt, exp_tz);
    chk("stat_busy", busy, exp_tc > 0);
    chk("stat_lv", level_valid, 0);
    for (int i = 0; i < exp_tc; i++) begin
      if (i == inject) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            drv[r][c] = 8'($urandom_range(1, 255));
        valid = 1'b1;
      end
      if (i == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        chk_zero_outputs("rst_mid");
        rst = 1'b0;
        return;
      end
      @(posedge clk); #1;
      valid = 1'b0;
      chk("lv", level_valid, 1);
      chk("level", $signed(level_o), exp_lv[i]);
      chk("run", run_before_o, exp_rb[i]);
      chk("last", level_last, i == exp_tc - 1);
      chk("emit_busy", busy, 1);
      chk("emit_sv", stats_valid, 0);
    end
    if (exp_tc > 0) begin
      @(posedge clk); #1;
      chk("done_busy", busy, 0);
      chk("done_lv", level_valid, 0);
    end
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("idle_lv", level_valid, 0);
    chk("idle_sv", stats_valid, 0);
    chk("hold_tc", total_coeff, exp_tc);
  endtask

  task automatic blk_one();
    set_row(0, -12, 7, 0, 1);
    set_row(1, 7, 1, -3, 0);
    set_row(2, 0, -5, -3, 0);
    set_row(3, 0, -2, 2, 1);
  endtask

  task automatic blk_two();
    set_row(0, -10, -1, -1, -1);
    set_row(1, -3, -1, -1, 0);
    set_row(2, 0, 0, -1, -1);
    set_row(3, -1, 0, -1, -1);
  endtask

  initial begin
    int sel;
    rst = 1'b1;
    valid = 1'b0;
    clear_blk();
    drv = blk;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    blk_one();
    run_block(-1, -1);
    chk("b1_tc", total_coeff, 11);
    chk("b1_t1", trailing_ones_cnt, 1);
    chk("b1_flag", trailing_ones_flag, 0);
    chk("b1_tz", total_zero_cnt, 5);

    blk_two();
    run_block(-1, -1);
    chk("b2_tc", total_coeff, 12);
    chk("b2_t1", trailing_ones_cnt, 3);
    chk("b2_flag", trailing_ones_flag, 7);
    chk("b2_tz", total_zero_cnt, 4);

    clear_blk();
    run_block(-1, -1);

    clear_blk();
    blk[3][3] = -8'sd1;
    run_block(-1, -1);
    chk("s33_tc", total_coeff, 1);
    chk("s33_flag", trailing_ones_flag, 1);
    chk("s33_tz", total_zero_cnt, 15);

    blk_one();
    run_block(3, -1);
    blk_one();
    run_block(10, -1);

    blk_two();
    run_block(-1, 4);
    blk_one();
    run_block(-1, -1);

    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          sel = $urandom_range(0, 9);
          if (sel < 5) blk[r][c] = 8'sd0;
          else if (sel < 8) blk[r][c] = ($urandom_range(0, 1) == 1) ? 8'sd1 : -8'sd1;
          else if (sel == 8) blk[r][c] = -8'sd128;
          else blk[r][c] = 8'($urandom_range(0, 255));
        end
      run_block((n % 4 == 0) ? int'($urandom_range(0, 3)) : -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
